// File: rtl/sample_burst_requester.sv
// sample_burst_requester
//
// Walks a table of sample descriptors and turns each one into a burst
// read request. Each request covers at most MAX_BURST beats. No more than
// MAX_OUTSTANDING requests may be accepted but not yet completed. A round
// ends when an entry flagged info_last has been requested or skipped. Once
// every outstanding request has completed and the receiver reports it has
// drained, the block starts the next round.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   start, stop          level controls: start enables rounds, stop aborts
//   info_*               current table entry (addr, id, remaining, valid, last)
//   info_next            one-cycle pulse asking the table for the next entry
//   req_addr/id/len      request fields (len = beats - 1), held stable while pending
//   req_valid/req_ready  request handshake
//   req_done             one pulse per completed request
//   all_data_received    receiver has drained the current round
//   last_req_sent        pulse when the round's final entry is accepted or skipped
//   last_req_id          ID of the most recently accepted request
//   outstanding          count of accepted, not yet completed requests
//   all_invalid          pulse when a round ends without issuing any request
module sample_burst_requester #(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 6,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] info_addr,
  input  logic [ID_W-1:0]   info_id,
  input  logic [31:0]       info_remaining,
  input  logic              info_valid,
  input  logic              info_last,
  output logic              info_next,
  output logic [ADDR_W-1:0] req_addr,
  output logic [ID_W-1:0]   req_id,
  output logic [7:0]        req_len,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic              req_done,
  input  logic              all_data_received,
  output logic              last_req_sent,
  output logic [ID_W-1:0]   last_req_id,
  output logic [3:0]        outstanding,
  output logic              all_invalid
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_INFO,
    ANALYZE,
    SEND,
    WAIT_ALL
  } state_t;

  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [3:0]  MAX_OUT     = 4'(MAX_OUTSTANDING);

  state_t            state_reg, state_next;
  logic [3:0]        outstanding_reg;
  logic              sent_reg;
  logic              last_reg;       // info_last captured with the request
  logic [ADDR_W-1:0] req_addr_reg;
  logic [ID_W-1:0]   req_id_reg;
  logic [7:0]        req_len_reg;
  logic [ID_W-1:0]   last_req_id_reg;

  logic              latch_en;
  logic              sent_clr;
  logic              accept;
  logic [31:0]       beats;
  logic [7:0]        len_calc;

  // Beats for this entry: the whole remainder, capped at one maximum burst.
  assign beats    = (info_remaining < MAX_BURST_W) ? info_remaining : MAX_BURST_W;
  assign len_calc = 8'(beats - 32'd1);

  assign accept = req_valid && req_ready;

  // Next-state and output decode
  always_comb begin
    state_next    = state_reg;
    info_next     = 1'b0;
    req_valid     = 1'b0;
    last_req_sent = 1'b0;
    all_invalid   = 1'b0;
    latch_en      = 1'b0;
    sent_clr      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop && info_valid && (outstanding_reg == 4'd0)) begin
          state_next = ANALYZE;
          sent_clr   = 1'b1;
        end
      end

      FETCH: begin
        info_next  = 1'b1;
        state_next = WAIT_INFO;
      end

      WAIT_INFO: begin
        if (stop) begin
          state_next = IDLE;
        end else if (info_valid) begin
          state_next = ANALYZE;
        end
      end

      ANALYZE: begin
        if (info_remaining == 32'd0) begin
          // An overflowed voice is skipped. If it closes the table, the round
          // still has to be reported as finished.
          if (info_last) begin
            state_next    = WAIT_ALL;
            last_req_sent = 1'b1;
          end else begin
            state_next = FETCH;
          end
        end else begin
          latch_en   = 1'b1;
          state_next = SEND;
        end
      end

      SEND: begin
        // The request waits only for a free outstanding slot. Completions can
        // only lower the count, so once valid rises it stays high until
        // acceptance. stop is looked at only once the request is accepted.
        req_valid = (outstanding_reg < MAX_OUT);
        if (req_valid && req_ready) begin
          if (last_reg) begin
            state_next    = WAIT_ALL;
            last_req_sent = 1'b1;
          end else if (stop) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end

      WAIT_ALL: begin
        if (stop) begin
          state_next = IDLE;
          sent_clr   = 1'b1;
        end else if (!sent_reg) begin
          all_invalid = 1'b1;
          state_next  = IDLE;
          sent_clr    = 1'b1;
        end else if ((outstanding_reg == 4'd0) && all_data_received) begin
          state_next = FETCH;
          sent_clr   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outstanding counter. It runs in every state, so completions that arrive
  // after a stop are still counted. An acceptance and a completion in the
  // same cycle cancel out. A completion at zero is dropped instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_reg <= 4'd0;
    end else begin
      case ({accept, req_done})
        2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
        2'b01:   if (outstanding_reg != 4'd0) outstanding_reg <= outstanding_reg - 4'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // Request fields, round bookkeeping and last accepted ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr_reg    <= '0;
      req_id_reg      <= '0;
      req_len_reg     <= '0;
      last_reg        <= 1'b0;
      sent_reg        <= 1'b0;
      last_req_id_reg <= '0;
    end else begin
      if (latch_en) begin
        req_addr_reg <= info_addr;
        req_id_reg   <= info_id;
        req_len_reg  <= len_calc;
        last_reg     <= info_last;
      end
      if (accept) begin
        sent_reg        <= 1'b1;
        last_req_id_reg <= req_id_reg;
      end else if (sent_clr) begin
        sent_reg <= 1'b0;
      end
    end
  end

  assign req_addr    = req_addr_reg;
  assign req_id      = req_id_reg;
  assign req_len     = req_len_reg;
  assign last_req_id = last_req_id_reg;
  assign outstanding = outstanding_reg;

endmodule

// File: tb/tb_sample_burst_requester.sv
// Testbench for sample_burst_requester.
// Two instances share every input. dut has MAX_BURST=64 and dut2 has
// MAX_BURST=256. Both have MAX_OUTSTANDING=2, so the two behave identically
// apart from req_len. The bench plays the descriptor table and the read
// receiver. A simple model derives the expected requests and counts from the
// table contents.
module tb_sample_burst_requester;

  localparam int AW  = 32;
  localparam int IW  = 6;
  localparam int MB  = 64;
  localparam int MB2 = 256;
  localparam int MO  = 2;

  logic          clk;
  logic          reset_n;
  logic          start, stop;
  logic [AW-1:0] info_addr;
  logic [IW-1:0] info_id;
  logic [31:0]   info_remaining;
  logic          info_valid, info_last;
  logic          req_ready, req_done, all_data_received;

  logic          info_next, req_valid, last_req_sent, all_invalid;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_id, last_req_id;
  logic [7:0]    req_len;
  logic [3:0]    outstanding;

  logic          info_next_2, req_valid_2, last_req_sent_2, all_invalid_2;
  logic [AW-1:0] req_addr_2;
  logic [IW-1:0] req_id_2, last_req_id_2;
  logic [7:0]    req_len_2;
  logic [3:0]    outstanding_2;

  sample_burst_requester #(.ADDR_W(AW), .ID_W(IW), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .info_addr(info_addr), .info_id(info_id), .info_remaining(info_remaining),
    .info_valid(info_valid), .info_last(info_last), .info_next(info_next),
    .req_addr(req_addr), .req_id(req_id), .req_len(req_len), .req_valid(req_valid),
    .req_ready(req_ready), .req_done(req_done), .all_data_received(all_data_received),
    .last_req_sent(last_req_sent), .last_req_id(last_req_id),
    .outstanding(outstanding), .all_invalid(all_invalid)
  );

  sample_burst_requester #(.ADDR_W(AW), .ID_W(IW), .MAX_BURST(MB2), .MAX_OUTSTANDING(MO)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .info_addr(info_addr), .info_id(info_id), .info_remaining(info_remaining),
    .info_valid(info_valid), .info_last(info_last), .info_next(info_next_2),
    .req_addr(req_addr_2), .req_id(req_id_2), .req_len(req_len_2), .req_valid(req_valid_2),
    .req_ready(req_ready), .req_done(req_done), .all_data_received(all_data_received),
    .last_req_sent(last_req_sent_2), .last_req_id(last_req_id_2),
    .outstanding(outstanding_2), .all_invalid(all_invalid_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // descriptor table
  logic [AW-1:0] ent_addr [16];
  logic [IW-1:0] ent_id   [16];
  int unsigned   ent_rem  [16];
  bit            ent_last [16];
  int            n_ent;
  int            idx;

  // receiver / stimulus knobs
  int  ready_pct;
  bit  done_en, stray_done, done_on_accept, ard_en;
  int  pend;                 // model: accepted-but-not-done count

  // per-round observations
  int  n_acc, lrs_cnt, ai_cnt;
  bit  s_valid, s_next;
  bit  hold_prev;
  logic [AW-1:0] prev_addr;
  logic [IW-1:0] prev_id;
  logic [7:0]    prev_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_len(input int unsigned rem, input int unsigned mb);
    int unsigned b;
    b = (rem < mb) ? rem : mb;
    return 8'(b - 1);
  endfunction

  // One clock cycle, entered and left at posedge+1.
  task automatic step();
    bit acc, dn;
    int pend_before;
    logic [IW-1:0] acc_id;
    info_addr         = ent_addr[idx];
    info_id           = ent_id[idx];
    info_remaining    = ent_rem[idx];
    info_last         = ent_last[idx];
    info_valid        = 1'b1;
    req_ready         = ($urandom_range(0, 99) < ready_pct);
    req_done          = (done_en && pend > 0 && $urandom_range(0, 99) < 40) || stray_done;
    all_data_received = ard_en && (pend == 0);
    #1;
    if (done_on_accept && req_valid && req_ready && pend > 0) req_done = 1'b1;
    #1;
    acc     = req_valid && req_ready;
    dn      = req_done;
    s_valid = req_valid;
    s_next  = info_next;
    acc_id  = req_id;
    if (hold_prev) begin
      chk("hold_valid", req_valid, 1'b1);
      chk("hold_addr", req_addr, prev_addr);
      chk("hold_id", req_id, prev_id);
      chk("hold_len", req_len, prev_len);
    end
    if (acc) begin
      chk("req_addr", req_addr, ent_addr[idx]);
      chk("req_id", req_id, ent_id[idx]);
      chk("req_len", req_len, exp_len(ent_rem[idx], MB));
      chk("req_len_mb256", req_len_2, exp_len(ent_rem[idx], MB2));
      chk("lrs_on_accept", last_req_sent, ent_last[idx]);
      $display("req: id=%0h addr=%0h rem=%0d len=%0d len256=%0d last=%0d",
               req_id, req_addr, ent_rem[idx], req_len, req_len_2, ent_last[idx]);
      n_acc++;
    end
    lrs_cnt += int'(last_req_sent);
    ai_cnt  += int'(all_invalid);
    hold_prev = req_valid && !req_ready;
    prev_addr = req_addr;
    prev_id   = req_id;
    prev_len  = req_len;
    pend_before = pend;
    @(posedge clk);
    #1;
    if (acc && !dn)            pend++;
    else if (!acc && dn && pend > 0) pend--;
    if (s_next) idx = (idx + 1) % n_ent;
    chk("outstanding", outstanding, 4'(pend));
    chk("out_le_max", outstanding <= 4'(MO), 1'b1);
    if (acc) chk("last_req_id", last_req_id, acc_id);
    if (acc && dn) chk("simul_out", outstanding, 4'(pend_before));
  endtask

  task automatic begin_round();
    idx = 0; n_acc = 0; lrs_cnt = 0; ai_cnt = 0; ard_en = 0;
    start = 1'b1; stop = 1'b0;
  endtask

  task automatic finish_round(input int exp_acc, input bit exp_inv);
    int budget;
    bit ended, restarted;
    budget = 3000; ended = 0; restarted = 0;
    done_en = 1;
    while (budget > 0 && !ended) begin
      step();
      budget--;
      if (ai_cnt > 0) ended = 1;
      else if (lrs_cnt > 0) begin
        ard_en = 1;
        if (s_next) begin restarted = 1; ended = 1; end
      end
    end
    chk("round_end", ended, 1'b1);
    if (restarted) begin
      stop = 1'b1;        // WAIT_INFO -> IDLE
      step();
      step();
      chk("idle_no_next", s_next, 1'b0);
      chk("idle_no_valid", s_valid, 1'b0);
    end
    start = 1'b0; stop = 1'b0; ard_en = 0;
    step();
    chk("post_round_valid", s_valid, 1'b0);
    chk("round_acc", n_acc, exp_acc);
    chk("round_lrs", lrs_cnt, 1);
    chk("round_all_invalid", ai_cnt, exp_inv);
    $display("round: entries=%0d accepted=%0d lrs=%0d all_invalid=%0d", n_ent, n_acc, lrs_cnt, ai_cnt);
  endtask

  task automatic drain();
    int budget;
    budget = 500;
    start = 1'b0; stop = 1'b0; done_en = 1;
    while (pend > 0 && budget > 0) begin step(); budget--; end
    chk("drained", budget > 0, 1'b1);
  endtask

  task automatic set_ent(input int i, input int unsigned rem, input bit last);
    ent_addr[i] = $urandom;
    ent_id[i]   = IW'($urandom);
    ent_rem[i]  = rem;
    ent_last[i] = last;
  endtask

  initial begin
    int wait_budget;
    int nz;
    reset_n = 1'b0; start = 0; stop = 0; info_valid = 0; info_last = 0;
    info_addr = '0; info_id = '0; info_remaining = '0;
    req_ready = 0; req_done = 0; all_data_received = 0;
    ready_pct = 100; done_en = 0; stray_done = 0; done_on_accept = 0; ard_en = 0;
    pend = 0; hold_prev = 0; n_ent = 1; idx = 0;
    n_acc = 0; lrs_cnt = 0; ai_cnt = 0;
    for (int i = 0; i < 16; i++) set_ent(i, 1, 1'b1);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_out", outstanding, 4'd0);
    chk("rst_addr", req_addr, '0);
    chk("rst_len", req_len, 8'd0);
    chk("rst_lrid", last_req_id, '0);
    chk("rst_pulses", {info_next, last_req_sent, all_invalid}, 3'b000);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // stray completion at zero is ignored
    stray_done = 1; step(); stray_done = 0;

    // V1: single entry, 100 samples, last
    n_ent = 1; set_ent(0, 100, 1'b1); ready_pct = 100;
    begin_round(); finish_round(1, 0); drain();

    // V2: short tail and a long entry
    n_ent = 2; set_ent(0, 5, 1'b0); set_ent(1, 300, 1'b1);
    begin_round(); finish_round(2, 0); drain();

    // V3: outstanding stall at MAX_OUTSTANDING=2
    n_ent = 3; set_ent(0, 10, 1'b0); set_ent(1, 20, 1'b0); set_ent(2, 30, 1'b1);
    done_en = 0; ready_pct = 100;
    begin_round();
    repeat (14) step();
    chk("stall_acc", n_acc, 2);
    chk("stall_valid", req_valid, 1'b0);
    stray_done = 1; step(); stray_done = 0;
    chk("stall_release", req_valid, 1'b1);
    finish_round(3, 0); drain();

    // V4: all entries overflowed
    n_ent = 3; set_ent(0, 0, 1'b0); set_ent(1, 0, 1'b0); set_ent(2, 0, 1'b1);
    begin_round(); finish_round(0, 1); drain();

    // V5: stop while a request is stalled on ready
    n_ent = 2; set_ent(0, 40, 1'b0); set_ent(1, 8, 1'b1);
    ready_pct = 0; done_en = 0;
    begin_round();
    wait_budget = 10;
    while (!s_valid && wait_budget > 0) begin step(); wait_budget--; end
    chk("v5_valid_seen", s_valid, 1'b1);
    stop = 1'b1;
    repeat (3) step();
    chk("v5_no_acc", n_acc, 0);
    ready_pct = 100;
    step();
    chk("v5_acc", n_acc, 1);
    ready_pct = 0;
    repeat (3) begin
      step();
      chk("v5_idle_next", s_next, 1'b0);
      chk("v5_idle_valid", s_valid, 1'b0);
    end
    ready_pct = 100; drain();

    // V6a: completion and acceptance in the same cycle
    n_ent = 2; set_ent(0, 7, 1'b0); set_ent(1, 9, 1'b1);
    done_en = 0; done_on_accept = 1;
    begin_round();
    repeat (8) step();
    done_on_accept = 0;
    finish_round(2, 0); drain();

    // random rounds
    for (int r = 0; r < 8; r++) begin
      n_ent = $urandom_range(1, 6);
      nz = 0;
      for (int i = 0; i < n_ent; i++) begin
        int unsigned rem;
        case ($urandom_range(0, 3))
          0:       rem = 0;
          1:       rem = $urandom_range(1, MB);
          2:       rem = $urandom_range(MB + 1, 400);
          default: rem = $urandom_range(1, 20);
        endcase
        if (rem != 0) nz++;
        set_ent(i, rem, i == n_ent - 1);
      end
      ready_pct = $urandom_range(30, 100);
      begin_round();
      finish_round(nz, nz == 0);
      drain();
    end

    // V6b: reset in the middle of SEND
    n_ent = 1; set_ent(0, 50, 1'b1); ready_pct = 0; done_en = 0;
    begin_round();
    wait_budget = 10;
    while (!s_valid && wait_budget > 0) begin step(); wait_budget--; end
    chk("v6_valid_seen", s_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("v6_rst_valid", req_valid, 1'b0);
    chk("v6_rst_out", outstanding, 4'd0);
    chk("v6_rst_fields", {req_addr, req_id, req_len, last_req_id}, '0);
    chk("v6_rst_pulses", {info_next, last_req_sent, all_invalid}, 3'b000);
    pend = 0; hold_prev = 0; start = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("v6_post_valid", req_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_burst_requester.md
SAMPLE_BURST_REQUESTER -- requirements
Module: sample_burst_requester

Interface
REQ-001 Parameter ADDR_W, default 32, sets the sample address width.
REQ-002 Parameter ID_W, default 6, sets the sample/request ID width.
REQ-003 Parameter MAX_BURST, default 64, sets the maximum beats per request (range 1..256).
REQ-004 Parameter MAX_OUTSTANDING, default 4, sets the maximum accepted-but-not-done requests (range 1..15).
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; enables request rounds.
- stop  in  1  level; aborts the current round.
- info_addr  in  ADDR_W  next sample address.
- info_id  in  ID_W  sample ID.
- info_remaining  in  32  samples left in the voice; 0 means overflowed.
- info_valid  in  1  info fields valid.
- info_last  in  1  last active sample in the table.
- info_next  out  1  one-cycle pulse requesting the next info entry.
- req_addr  out  ADDR_W  request address.
- req_id  out  ID_W  request ID.
- req_len  out  8  request beats minus 1.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_done  in  1  one pulse per completed request.
- all_data_received  in  1  receiver has drained the round.
- last_req_sent  out  1  pulse when the round's final request is accepted, or when the final entry is skipped.
- last_req_id  out  ID_W  ID of the most recently accepted request.
- outstanding  out  4  accepted-not-done count.
- all_invalid  out  1  pulse when a round ends with zero requests.

Function
REQ-006 The FSM SHALL have states IDLE, FETCH, WAIT_INFO, ANALYZE, SEND and WAIT_ALL.
REQ-007 IDLE SHALL go to ANALYZE when start && !stop && info_valid && outstanding==0; otherwise it stays in IDLE.
REQ-008 FETCH SHALL assert info_next for exactly 1 cycle, then go to WAIT_INFO.
REQ-009 WAIT_INFO SHALL go to IDLE on stop, else to ANALYZE on info_valid, else hold.
REQ-010 ANALYZE (1 cycle) SHALL branch as follows:
- info_remaining==0 && info_last: go to WAIT_ALL and pulse last_req_sent.
- info_remaining==0 && !info_last: go to FETCH.
- otherwise: latch addr/id/len and go to SEND.
REQ-011 The latched req_len SHALL equal min(info_remaining, MAX_BURST)-1, computed in 32 bits and truncated to 8.
REQ-012 In SEND, req_valid SHALL equal (outstanding < MAX_OUTSTANDING).
REQ-013 Once req_valid is asserted, req_valid and the req_* fields SHALL stay asserted and stable until req_ready.
REQ-014 stop in SEND SHALL be ignored until the request is accepted.
REQ-015 On acceptance in SEND:
- last_req_id SHALL update to req_id on the next edge.
- info_last: go to WAIT_ALL and pulse last_req_sent that cycle.
- !info_last: go to FETCH, or to IDLE if stop is high.
REQ-016 The outstanding counter SHALL behave as follows:
- +1 on req_valid&&req_ready.
- -1 on req_done.
- Unchanged when both occur in the same cycle.
- Never wraps: req_done at 0 is ignored.
- Keeps counting in every state, including IDLE.
REQ-017 A sent flag SHALL clear on entry to ANALYZE from IDLE and on exit from WAIT_ALL, and SHALL set on any acceptance.
REQ-018 WAIT_ALL SHALL branch as follows:
- stop: go to IDLE.
- !sent: pulse all_invalid and go to IDLE.
- outstanding==0 && all_data_received: go to FETCH (next round).
- otherwise: hold.
REQ-019 Latency from ANALYZE to the first req_valid SHALL be 1 cycle, provided there is no outstanding stall.

Reset
REQ-020 While reset_n is low:
- State SHALL be IDLE.
- outstanding, last_req_id, req_addr, req_id and req_len SHALL be 0.
- sent SHALL be 0.
- All pulse and valid outputs SHALL be 0.
REQ-021 Reset asserted mid-request SHALL drop req_valid immediately (asynchronously) and SHALL discard the outstanding count.

Verification
REQ-022 Scenario V1 (single entry, partial burst):
- Stimulus: one entry, remaining=100, last=1, ready tied high.
- Response: req_len=63, last_req_sent pulses, state goes to WAIT_ALL.
- Then: after done and all_data_received, the block returns to FETCH.
REQ-023 Scenario V2 (short tail):
- Stimulus: remaining=5.
- Response: req_len=4.
- Stimulus: remaining=300, MAX_BURST=256.
- Response: req_len=255.
REQ-024 Scenario V3 (outstanding stall):
- Stimulus: MAX_OUTSTANDING=2, 3 entries, no req_done.
- Response: the third req_valid stays low until one req_done arrives, then asserts the next cycle.
- Check: outstanding never exceeds 2.
REQ-025 Scenario V4 (all entries overflowed):
- Stimulus: all entries remaining=0, the last with last=1.
- Response: zero requests, last_req_sent pulse, all_invalid pulse, state IDLE.
REQ-026 Scenario V5 (stop during SEND):
- Stimulus: stop raised while req_valid is high and req_ready is low for 3 cycles.
- Response: req_valid holds and fields stay stable; IDLE is reached the cycle after acceptance.
REQ-027 Scenario V6 (simultaneous events):
- Stimulus: req_done and an acceptance in the same cycle.
- Response: outstanding unchanged.
- Stimulus: reset asserted mid-SEND.
- Response: all outputs 0 immediately.
